watch_timekeeper: RTL and testbench

Binary timekeeping core of the digital watch. It derives a one-second enable from the system clock and counts seconds, minutes and hours as 6-bit binary values (0–59, 0–59, 0–23). A two-key set-mode state machine lets the user adjust hours and minutes. Each 6-bit output feeds a downstream binary-to-BCD stage that drives the display digits.

---
 rtl/watch_timekeeper.sv | 119 +++++++++++
 tb/tb_watch_timekeeper.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_timekeeper.sv
// Binary timekeeping core: one-second prescaler, sec/min/hour counters and a
// two-key set-mode state machine (RUN -> SET_HOUR -> SET_MIN -> RUN).
module watch_timekeeper #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int PRESCALE_W    = 26
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       mode_key,
  input  logic       inc_key,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [5:0] hours,
  output logic [1:0] set_mode,
  output logic       sec_tick
);

  localparam logic [1:0] MODE_RUN      = 2'b00;
  localparam logic [1:0] MODE_SET_HOUR = 2'b01;
  localparam logic [1:0] MODE_SET_MIN  = 2'b10;

  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(TICKS_PER_SEC - 1);

  logic                  mode_prev;
  logic                  inc_prev;
  logic                  mode_edge;
  logic                  inc_edge;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] prescale_nxt;
  logic [1:0]            mode_nxt;
  logic [5:0]            sec_nxt;
  logic [5:0]            min_nxt;
  logic [5:0]            hour_nxt;
  logic                  tick;

  // Wraps to 0 at `last`; any out-of-range value also loads 0.
  function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] last);
    return (value >= last) ? 6'd0 : value + 6'd1;
  endfunction

  assign mode_edge = mode_key & ~mode_prev;
  assign inc_edge  = inc_key  & ~inc_prev;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    mode_nxt     = set_mode;
    prescale_nxt = '0;
    sec_nxt      = seconds;
    min_nxt      = minutes;
    hour_nxt     = hours;
    tick         = 1'b0;

    if (mode_edge) begin
      // A mode edge wins over both the inc key and a coincident prescaler wrap.
      case (set_mode)
        MODE_RUN:      mode_nxt = MODE_SET_HOUR;
        MODE_SET_HOUR: mode_nxt = MODE_SET_MIN;
        MODE_SET_MIN: begin
          mode_nxt = MODE_RUN;
          sec_nxt  = 6'd0;
        end
        default:       mode_nxt = MODE_RUN;
      endcase
    end else begin
      case (set_mode)
        MODE_RUN: begin
          if (prescale >= PRESCALE_LAST) begin
            tick    = 1'b1;
            sec_nxt = wrap_inc(seconds, 6'd59);
            if (seconds == 6'd59) begin
              min_nxt = wrap_inc(minutes, 6'd59);
              if (minutes == 6'd59) begin
                hour_nxt = wrap_inc(hours, 6'd23);
              end
            end
          end else begin
            prescale_nxt = prescale + 1'b1;
          end
        end
        MODE_SET_HOUR: begin
          if (inc_edge) begin
            hour_nxt = wrap_inc(hours, 6'd23);
          end
        end
        MODE_SET_MIN: begin
          if (inc_edge) begin
            min_nxt = wrap_inc(minutes, 6'd59);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // Key history resets high so a key held through reset yields no edge.
      mode_prev <= 1'b1;
      inc_prev  <= 1'b1;
      prescale  <= '0;
      seconds   <= 6'd0;
      minutes   <= 6'd0;
      hours     <= 6'd0;
      set_mode  <= MODE_RUN;
      sec_tick  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample the pre-edge values, as real flops do.
      mode_prev <= mode_key;
      inc_prev  <= inc_key;
      prescale  <= prescale_nxt;
      seconds   <= sec_nxt;
      minutes   <= min_nxt;
      hours     <= hour_nxt;
      set_mode  <= mode_nxt;
      sec_tick  <= tick;
    end
  end

endmodule

// File: tb/tb_watch_timekeeper.sv
// Scoreboard bench for watch_timekeeper with TICKS_PER_SEC = 4: stimulus queues
// expected ticks, a negedge monitor pops and compares each sec_tick.
module tb_watch_timekeeper;

  localparam int TPS = 4;

  logic       clock    = 1'b0;
  logic       reset_n  = 1'b1;
  logic       mode_key = 1'b0;
  logic       inc_key  = 1'b0;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [5:0] hours;
  logic [1:0] set_mode;
  logic       sec_tick;

  watch_timekeeper #(
    .TICKS_PER_SEC(TPS),
    .PRESCALE_W   (3)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .mode_key(mode_key),
    .inc_key (inc_key),
    .seconds (seconds),
    .minutes (minutes),
    .hours   (hours),
    .set_mode(set_mode),
    .sec_tick(sec_tick)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [5:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } tick_exp_t;

  tick_exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int model_h, model_m, model_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference clock model: advance one second, push expected tick at base + TPS*k.
  task automatic expect_ticks(input int base, input int n);
    tick_exp_t e;
    for (int k = 1; k <= n; k++) begin
      if (model_s == 59) begin
        model_s = 0;
        if (model_m == 59) begin
          model_m = 0;
          model_h = (model_h == 23) ? 0 : model_h + 1;
        end else begin
          model_m = model_m + 1;
        end
      end else begin
        model_s = model_s + 1;
      end
      e.cyc = base + TPS * k;
      e.h   = 6'(model_h);
      e.m   = 6'(model_m);
      e.s   = 6'(model_s);
      exp_q.push_back(e);
    end
  endtask

  task automatic press_mode(output int ev_cyc);
    mode_key = 1'b1;
    @(negedge clock);
    ev_cyc   = cyc;
    mode_key = 1'b0;
    @(negedge clock);
  endtask

  task automatic press_inc(input int n);
    repeat (n) begin
      inc_key = 1'b1;
      @(negedge clock);
      inc_key = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  // Monitor: every sec_tick must match the head of the expectation queue.
  always @(negedge clock) begin
    tick_exp_t e;
    if (reset_n === 1'b1 && sec_tick !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: got sec_tick=%b with no tick expected at cycle %0d", sec_tick, cyc);
      end else begin
        e = exp_q.pop_front();
        check("tick_cycle", cyc, e.cyc);
        check("tick_hms", {hours, minutes, seconds}, {e.h, e.m, e.s});
        check("tick_mode", set_mode, 2'b00);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rel, ev, c;

    // Reset state
    #1 reset_n = 1'b0;
    #3;
    check("reset_sec", seconds, 0);
    check("reset_min", minutes, 0);
    check("reset_hour", hours, 0);
    check("reset_mode", set_mode, 0);
    check("reset_tick", sec_tick, 0);
    @(negedge clock);
    @(negedge clock);

    // Free run: 61 ticks, every 4 cycles
    reset_n = 1'b1;
    rel = cyc;
    model_h = 0; model_m = 0; model_s = 0;
    expect_ticks(rel, 61);
    wait_until(rel + 4 * 61);
    @(negedge clock);
    check("free_run_drained", exp_q.size(), 0);
    check("free_run_min", minutes, 1);
    check("free_run_sec", seconds, 1);

    // Keys held high through reset give no edge after release
    mode_key = 1'b1;
    inc_key  = 1'b1;
    reset_n  = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("held_keys_mode", set_mode, 0);
    check("held_keys_hour", hours, 0);
    mode_key = 1'b0;
    inc_key  = 1'b0;
    @(negedge clock);

    // Set flow
    press_mode(ev);
    check("enter_set_hour", set_mode, 1);
    press_inc(25);
    check("hour_25_presses", hours, 1);
    press_mode(ev);
    check("enter_set_min", set_mode, 2);
    press_inc(61);
    check("min_61_presses", minutes, 1);
    check("hour_kept", hours, 1);
    press_mode(c);
    check("back_to_run", set_mode, 0);
    check("run_sec_cleared", seconds, 0);
    model_h = 1; model_m = 1; model_s = 0;
    expect_ticks(c, 2);
    wait_until(c + 8);
    press_mode(ev);
    check("set_flow_drained", exp_q.size(), 0);
    check("frozen_sec", seconds, 2);

    // Held inc key counts once
    inc_key = 1'b1;
    repeat (20) @(negedge clock);
    inc_key = 1'b0;
    @(negedge clock);
    check("hold_inc_once", hours, 2);
    press_inc(21);
    check("hour_23", hours, 23);

    // Simultaneous mode+inc: only mode advances
    mode_key = 1'b1;
    inc_key  = 1'b1;
    @(negedge clock);
    mode_key = 1'b0;
    inc_key  = 1'b0;
    @(negedge clock);
    check("simul_mode", set_mode, 2);
    check("simul_hour", hours, 23);
    check("simul_min", minutes, 1);
    press_inc(58);
    check("min_59", minutes, 59);

    // Full rollover 23:59:59 -> 00:00:00
    press_mode(c);
    check("rollover_start_sec", seconds, 0);
    model_h = 23; model_m = 59; model_s = 0;
    expect_ticks(c, 116);
    wait_until(c + 240);
    check("rollover_hms", {hours, minutes, seconds}, 18'd0);
    check("rollover_tick", sec_tick, 1);
    wait_until(c + 464);
    check("sec_56", seconds, 56);

    // Build 12:34:56 in SET_MIN, then async reset mid-period
    press_mode(ev);
    press_inc(12);
    press_mode(ev);
    press_inc(34);
    check("preset_hms", {hours, minutes, seconds}, {6'd12, 6'd34, 6'd56});
    check("preset_mode", set_mode, 2);
    check("preset_drained", exp_q.size(), 0);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_hms", {hours, minutes, seconds}, 18'd0);
    check("async_mode", set_mode, 0);
    check("async_tick", sec_tick, 0);
    @(negedge clock);
    reset_n = 1'b1;
    rel = cyc;
    model_h = 0; model_m = 0; model_s = 0;
    expect_ticks(rel, 1);
    wait_until(rel + 4);
    @(negedge clock);
    check("post_reset_drained", exp_q.size(), 0);
    check("post_reset_sec", seconds, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
